// File: rtl/ca_code_gen_if.sv
// -----------------------------------------------------------------------------
// ca_code_gen_if
// Groups the strobe, control and replica-output signals of one C/A code
// tracking channel.
//   master : drives chip_en, half_en, load, prn_sel; observes the replicas
//   slave  : the code generator itself
// Signals:
//   chip_en   one-cycle chip strobe (prescaler 0 deg pulse)
//   half_en   one-cycle half-chip strobe (prescaler 180 deg pulse)
//   load      synchronous restart, samples prn_sel
//   prn_sel   PRN number 1..32
//   early     replica chip, half a chip ahead of prompt
//   prompt    prompt replica chip
//   late      replica chip, half a chip behind prompt
//   chip_idx  index 0..1022 of the chip currently on early
//   epoch     one-cycle pulse when chip 0 enters early
//   prn_err   high while the latched PRN is invalid
// -----------------------------------------------------------------------------
interface ca_code_gen_if #(
   parameter int IDX_W = 10
);
   logic             chip_en;
   logic             half_en;
   logic             load;
   logic [5:0]       prn_sel;
   logic             early;
   logic             prompt;
   logic             late;
   logic [IDX_W-1:0] chip_idx;
   logic             epoch;
   logic             prn_err;

   modport master (
      output chip_en, half_en, load, prn_sel,
      input  early, prompt, late, chip_idx, epoch, prn_err
   );

   modport slave (
      input  chip_en, half_en, load, prn_sel,
      output early, prompt, late, chip_idx, epoch, prn_err
   );
endinterface

// File: rtl/ca_code_gen.sv
// -----------------------------------------------------------------------------
// ca_code_gen
// GPS L1 C/A Gold-code generator for one tracking channel. Produces early,
// prompt and late replica chips at half-chip spacing, the code-phase index of
// the early chip and a 1 ms epoch strobe.
// Ports:
//   clk_in  system clock, all logic on posedge
//   rst     asynchronous active-high reset
//   bus     ca_code_gen_if.slave (strobes, load/prn_sel, replica outputs)
// Parameters:
//   DEFAULT_PRN  PRN latched at reset (1..32 valid)
//   IDX_W        width of chip_idx
// -----------------------------------------------------------------------------
module ca_code_gen #(
   parameter int DEFAULT_PRN = 1,
   parameter int IDX_W       = 10
) (
   input  logic          clk_in,
   input  logic          rst,
   ca_code_gen_if.slave  bus
);

   localparam int               CODE_LEN  = 1023;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [5:0]       RESET_PRN = 6'(DEFAULT_PRN);
   localparam logic             RESET_ERR = (DEFAULT_PRN < 1) || (DEFAULT_PRN > 32);
   localparam logic [10:1]      LFSR_INIT = 10'h3FF;

   // LFSR stages numbered 1..10 to match the ICD; stage 10 is the output.
   logic [10:1]      g1_q, g1_d;
   logic [10:1]      g2_q, g2_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [5:0]       prn_q, prn_d;
   logic             prn_err_q, prn_err_d;
   logic             early_q, early_d;
   logic             prompt_q, prompt_d;
   logic             late_q, late_d;
   logic [IDX_W-1:0] chip_idx_q, chip_idx_d;
   logic             epoch_q, epoch_d;

   logic [3:0]       tap_a, tap_b;
   logic             g1_fb, g2_fb, code;

   // G2 phase-selector taps per PRN. Invalid PRNs get a harmless pair; their
   // output is masked by prn_err anyway.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      tap_a = 4'd1;
      tap_b = 4'd2;
      case (prn_q)
         6'd1:  begin tap_a = 4'd2; tap_b = 4'd6;  end
         6'd2:  begin tap_a = 4'd3; tap_b = 4'd7;  end
         6'd3:  begin tap_a = 4'd4; tap_b = 4'd8;  end
         6'd4:  begin tap_a = 4'd5; tap_b = 4'd9;  end
         6'd5:  begin tap_a = 4'd1; tap_b = 4'd9;  end
         6'd6:  begin tap_a = 4'd2; tap_b = 4'd10; end
         6'd7:  begin tap_a = 4'd1; tap_b = 4'd8;  end
         6'd8:  begin tap_a = 4'd2; tap_b = 4'd9;  end
         6'd9:  begin tap_a = 4'd3; tap_b = 4'd10; end
         6'd10: begin tap_a = 4'd2; tap_b = 4'd3;  end
         6'd11: begin tap_a = 4'd3; tap_b = 4'd4;  end
         6'd12: begin tap_a = 4'd5; tap_b = 4'd6;  end
         6'd13: begin tap_a = 4'd6; tap_b = 4'd7;  end
         6'd14: begin tap_a = 4'd7; tap_b = 4'd8;  end
         6'd15: begin tap_a = 4'd8; tap_b = 4'd9;  end
         6'd16: begin tap_a = 4'd9; tap_b = 4'd10; end
         6'd17: begin tap_a = 4'd1; tap_b = 4'd4;  end
         6'd18: begin tap_a = 4'd2; tap_b = 4'd5;  end
         6'd19: begin tap_a = 4'd3; tap_b = 4'd6;  end
         6'd20: begin tap_a = 4'd4; tap_b = 4'd7;  end
         6'd21: begin tap_a = 4'd5; tap_b = 4'd8;  end
         6'd22: begin tap_a = 4'd6; tap_b = 4'd9;  end
         6'd23: begin tap_a = 4'd1; tap_b = 4'd3;  end
         6'd24: begin tap_a = 4'd4; tap_b = 4'd6;  end
         6'd25: begin tap_a = 4'd5; tap_b = 4'd7;  end
         6'd26: begin tap_a = 4'd6; tap_b = 4'd8;  end
         6'd27: begin tap_a = 4'd7; tap_b = 4'd9;  end
         6'd28: begin tap_a = 4'd8; tap_b = 4'd10; end
         6'd29: begin tap_a = 4'd1; tap_b = 4'd6;  end
         6'd30: begin tap_a = 4'd2; tap_b = 4'd7;  end
         6'd31: begin tap_a = 4'd3; tap_b = 4'd8;  end
         6'd32: begin tap_a = 4'd4; tap_b = 4'd9;  end
         default: ;
      endcase
   end

   assign g1_fb = g1_q[3] ^ g1_q[10];
   assign g2_fb = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];
   assign code  = g1_q[10] ^ g2_q[tap_a] ^ g2_q[tap_b];

   always_comb begin
      g1_d       = g1_q;
      g2_d       = g2_q;
      cnt_d      = cnt_q;
      prn_d      = prn_q;
      prn_err_d  = prn_err_q;
      early_d    = early_q;
      prompt_d   = prompt_q;
      late_d     = late_q;
      chip_idx_d = chip_idx_q;
      epoch_d    = 1'b0;

      if (bus.load) begin
         // Restart dominates both strobes.
         prn_d      = bus.prn_sel;
         prn_err_d  = (bus.prn_sel == 6'd0) || (bus.prn_sel > 6'd32);
         g1_d       = LFSR_INIT;
         g2_d       = LFSR_INIT;
         cnt_d      = '0;
         early_d    = 1'b0;
         prompt_d   = 1'b0;
         late_d     = 1'b0;
         chip_idx_d = '0;
      end else begin
         // Both strobes read pre-edge values, so a coincident chip_en and
         // half_en shift the whole early/prompt/late pipe consistently.
         if (bus.chip_en) begin
            early_d    = code & ~prn_err_q;
            chip_idx_d = cnt_q;
            epoch_d    = (cnt_q == '0);
            late_d     = prompt_q;
            if (cnt_q == LAST_IDX) begin
               // Forced reload keeps the code aligned even if an LFSR were
               // ever corrupted.
               cnt_d = '0;
               g1_d  = LFSR_INIT;
               g2_d  = LFSR_INIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
               g1_d  = {g1_q[9:1], g1_fb};
               g2_d  = {g2_q[9:1], g2_fb};
            end
         end
         if (bus.half_en) begin
            prompt_d = early_q;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         g1_q       <= LFSR_INIT;
         g2_q       <= LFSR_INIT;
         cnt_q      <= '0;
         prn_q      <= RESET_PRN;
         prn_err_q  <= RESET_ERR;
         early_q    <= 1'b0;
         prompt_q   <= 1'b0;
         late_q     <= 1'b0;
         chip_idx_q <= '0;
         epoch_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge
         // values regardless of statement order.
         g1_q       <= g1_d;
         g2_q       <= g2_d;
         cnt_q      <= cnt_d;
         prn_q      <= prn_d;
         prn_err_q  <= prn_err_d;
         early_q    <= early_d;
         prompt_q   <= prompt_d;
         late_q     <= late_d;
         chip_idx_q <= chip_idx_d;
         epoch_q    <= epoch_d;
      end
   end

   assign bus.early    = early_q;
   assign bus.prompt   = prompt_q;
   assign bus.late     = late_q;
   assign bus.chip_idx = chip_idx_q;
   assign bus.epoch    = epoch_q;
   assign bus.prn_err  = prn_err_q;

endmodule
